// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage datapath.
//   XLEN_DEF        default datapath width
//   alu_op_e        ALU operation codes (11-15 reserved, result 0)
//   BR_*            bit positions inside the one-hot branch vector
//   FLAG_*          bit positions inside the {N,Z,C,V} flag vector
package exec_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    localparam int unsigned BR_BEQ  = 0;
    localparam int unsigned BR_BNE  = 1;
    localparam int unsigned BR_BLT  = 2;
    localparam int unsigned BR_BGE  = 3;
    localparam int unsigned BR_BLTU = 4;
    localparam int unsigned BR_BGEU = 5;

    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/exec_branch_unit_if.sv
// Bus between the core control/operand muxing (master) and the execute unit (slave).
//   master drives: alu_a, alu_b, alu_control, pc, rs1_data, imm, pc_target_src, branch, jump
//   slave drives : alu_result, flags, pc_plus_inc, pc_target, pc_next_src, pc_next,
//                  result_q, flags_q, taken_q
interface exec_branch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] imm;
    logic            pc_target_src;
    logic [5:0]      branch;
    logic            jump;

    logic [XLEN-1:0] alu_result;
    logic [3:0]      flags;
    logic [XLEN-1:0] pc_plus_inc;
    logic [XLEN-1:0] pc_target;
    logic            pc_next_src;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] result_q;
    logic [3:0]      flags_q;
    logic            taken_q;

    modport master (
        output alu_a, alu_b, alu_control, pc, rs1_data, imm, pc_target_src, branch, jump,
        input  alu_result, flags, pc_plus_inc, pc_target, pc_next_src, pc_next,
               result_q, flags_q, taken_q
    );

    modport slave (
        input  alu_a, alu_b, alu_control, pc, rs1_data, imm, pc_target_src, branch, jump,
        output alu_result, flags, pc_plus_inc, pc_target, pc_next_src, pc_next,
               result_q, flags_q, taken_q
    );
endinterface

// File: rtl/exec_alu.sv
// Purely combinational ALU with {N,Z,C,V} flags.
//   i_a, i_b   operands
//   i_op       operation code (alu_op_e encoding; 11-15 give result 0)
//   o_result   ALU result
//   o_flags    {N,Z,C,V}; N/Z from result for every op, C/V only for ADD/SUB/SLT/SLTU
module exec_alu
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_result,
    output logic [3:0]      o_flags
);

    logic [XLEN:0]   w_add_full;
    logic [XLEN:0]   w_sub_full;
    logic [XLEN-1:0] w_add;
    logic [XLEN-1:0] w_sub;
    logic            w_add_v;
    logic            w_sub_v;
    logic [4:0]      w_shamt;

    // Subtraction as a + ~b + 1 so the carry-out directly means "no borrow".
    assign w_add_full = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub_full = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
    assign w_add      = w_add_full[XLEN-1:0];
    assign w_sub      = w_sub_full[XLEN-1:0];
    assign w_add_v    = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_add[XLEN-1] != i_a[XLEN-1]);
    assign w_sub_v    = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_sub[XLEN-1] != i_a[XLEN-1]);
    assign w_shamt    = i_b[4:0];

    always_comb begin
        o_result = '0;
        o_flags  = '0;
        case (i_op)
            ALU_ADD: begin
                o_result        = w_add;
                o_flags[FLAG_C] = w_add_full[XLEN];
                o_flags[FLAG_V] = w_add_v;
            end
            ALU_SUB: begin
                o_result        = w_sub;
                o_flags[FLAG_C] = w_sub_full[XLEN];
                o_flags[FLAG_V] = w_sub_v;
            end
            ALU_AND:    o_result = i_a & i_b;
            ALU_OR:     o_result = i_a | i_b;
            ALU_XOR:    o_result = i_a ^ i_b;
            ALU_SLL:    o_result = i_a << w_shamt;
            ALU_SRL:    o_result = i_a >> w_shamt;
            ALU_SRA:    o_result = $signed(i_a) >>> w_shamt;
            ALU_SLT: begin
                // signed less-than is N^V of the subtraction
                o_result        = {{(XLEN-1){1'b0}}, w_sub[XLEN-1] ^ w_sub_v};
                o_flags[FLAG_C] = w_sub_full[XLEN];
                o_flags[FLAG_V] = w_sub_v;
            end
            ALU_SLTU: begin
                o_result        = {{(XLEN-1){1'b0}}, ~w_sub_full[XLEN]};
                o_flags[FLAG_C] = w_sub_full[XLEN];
                o_flags[FLAG_V] = w_sub_v;
            end
            ALU_PASS_B: o_result = i_b;
            default:    o_result = '0;
        endcase
        o_flags[FLAG_N] = o_result[XLEN-1];
        o_flags[FLAG_Z] = (o_result == '0);
    end

endmodule

// File: rtl/exec_branch_unit.sv
// Execute stage of the single-cycle RV32I core: ALU, PC+inc adder, PC-target adder and
// branch/jump resolution, all combinational, plus a registered trace copy.
//   clk     rising-edge clock
//   rst     asynchronous active-low reset (clears the trace registers only)
//   bus     exec_branch_unit_if slave: operands/control in, results/next-PC/trace out
module exec_branch_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned PC_INC = 1
) (
    input  logic                clk,
    input  logic                rst,
    exec_branch_unit_if.slave   bus
);

    logic [XLEN-1:0] w_alu_result;
    logic [3:0]      w_flags;
    logic [XLEN-1:0] w_target_base;
    logic [XLEN-1:0] w_pc_plus_inc;
    logic [XLEN-1:0] w_pc_target;
    logic [5:0]      w_cond;
    logic            w_pc_next_src;

    logic [XLEN-1:0] r_result_q;
    logic [3:0]      r_flags_q;
    logic            r_taken_q;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (bus.alu_a),
        .i_b      (bus.alu_b),
        .i_op     (bus.alu_control),
        .o_result (w_alu_result),
        .o_flags  (w_flags)
    );

    assign w_target_base = bus.pc_target_src ? bus.pc : bus.rs1_data;
    assign w_pc_target   = w_target_base + bus.imm;
    assign w_pc_plus_inc = bus.pc + XLEN'(PC_INC);

    // Conditions assume the control unit selected SUB for branches.
    always_comb begin
        w_cond          = '0;
        w_cond[BR_BEQ]  =  w_flags[FLAG_Z];
        w_cond[BR_BNE]  = ~w_flags[FLAG_Z];
        w_cond[BR_BLT]  =  w_flags[FLAG_N] ^ w_flags[FLAG_V];
        w_cond[BR_BGE]  = ~(w_flags[FLAG_N] ^ w_flags[FLAG_V]);
        w_cond[BR_BLTU] = ~w_flags[FLAG_C];
        w_cond[BR_BGEU] =  w_flags[FLAG_C];
    end

    assign w_pc_next_src = bus.jump | (|(bus.branch & w_cond));

    assign bus.alu_result  = w_alu_result;
    assign bus.flags       = w_flags;
    assign bus.pc_plus_inc = w_pc_plus_inc;
    assign bus.pc_target   = w_pc_target;
    assign bus.pc_next_src = w_pc_next_src;
    assign bus.pc_next     = w_pc_next_src ? w_pc_target : w_pc_plus_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result_q <= '0;
            r_flags_q  <= '0;
            r_taken_q  <= 1'b0;
        end else begin
            r_result_q <= w_alu_result;
            r_flags_q  <= w_flags;
            r_taken_q  <= w_pc_next_src;
        end
    end

    assign bus.result_q = r_result_q;
    assign bus.flags_q  = r_flags_q;
    assign bus.taken_q  = r_taken_q;

endmodule

// File: tb/tb_exec_branch_unit.sv
// Directed self-checking bench for exec_branch_unit.
module tb_exec_branch_unit;
    import exec_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    exec_branch_unit_if #(.XLEN(32)) bus ();

    exec_branch_unit #(.XLEN(32), .PC_INC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control = op;
        bus.alu_a       = a;
        bus.alu_b       = b;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.alu_a = '0; bus.alu_b = '0; bus.alu_control = 4'd0;
        bus.pc = '0; bus.rs1_data = '0; bus.imm = '0;
        bus.pc_target_src = 1'b0; bus.branch = '0; bus.jump = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_result_q", bus.result_q, 32'h0);
        check("rst_flags_q", {28'h0, bus.flags_q}, 32'h0);
        check("rst_taken_q", {31'h0, bus.taken_q}, 32'h0);

        // ADD overflow and carry
        set_alu(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf_res", bus.alu_result, 32'h8000_0000);
        check("add_ovf_flg", {28'h0, bus.flags}, 32'h9);
        set_alu(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
        check("add_cy_res", bus.alu_result, 32'h0);
        check("add_cy_flg", {28'h0, bus.flags}, 32'h6);

        // SUB 5-5 with BEQ / BNE, target relative to pc
        bus.pc = 32'h40; bus.imm = 32'h10; bus.pc_target_src = 1'b1;
        bus.branch = 6'b000001;
        set_alu(ALU_SUB, 32'd5, 32'd5);
        check("beq_flags", {28'h0, bus.flags}, 32'h6);
        check("beq_src", {31'h0, bus.pc_next_src}, 32'h1);
        check("beq_target", bus.pc_target, 32'h50);
        check("beq_next", bus.pc_next, 32'h50);
        bus.branch = 6'b000010; #1;
        check("bne_src", {31'h0, bus.pc_next_src}, 32'h0);
        check("bne_next", bus.pc_next, 32'h41);
        bus.branch = 6'b000000; #1;
        check("nobr_src", {31'h0, bus.pc_next_src}, 32'h0);

        // SUB -1 vs 1: signed less, unsigned greater-or-equal
        set_alu(ALU_SUB, 32'hFFFF_FFFF, 32'h1);
        check("sub_m1_res", bus.alu_result, 32'hFFFF_FFFE);
        check("sub_m1_flg", {28'h0, bus.flags}, 32'hA);
        bus.branch = 6'b000100; #1;
        check("blt_src", {31'h0, bus.pc_next_src}, 32'h1);
        bus.branch = 6'b001000; #1;
        check("bge_src", {31'h0, bus.pc_next_src}, 32'h0);
        bus.branch = 6'b010000; #1;
        check("bltu_src", {31'h0, bus.pc_next_src}, 32'h0);
        bus.branch = 6'b100000; #1;
        check("bgeu_src", {31'h0, bus.pc_next_src}, 32'h1);
        bus.branch = 6'b011000; #1;
        check("multi_br_src", {31'h0, bus.pc_next_src}, 32'h0);
        bus.branch = 6'b010100; #1;
        check("multi_br_or", {31'h0, bus.pc_next_src}, 32'h1);
        bus.branch = '0;

        // Shifts, compares, logic ops, pass-through, reserved
        set_alu(ALU_SRA, 32'h8000_0000, 32'd33);
        check("sra_res", bus.alu_result, 32'hC000_0000);
        check("sra_flg", {28'h0, bus.flags}, 32'h8);
        set_alu(ALU_SRL, 32'h8000_0000, 32'd31);
        check("srl_res", bus.alu_result, 32'h1);
        set_alu(ALU_SLL, 32'h1, 32'h24);
        check("sll_res", bus.alu_result, 32'h10);
        set_alu(ALU_SLTU, 32'h0, 32'hFFFF_FFFF);
        check("sltu_res", bus.alu_result, 32'h1);
        check("sltu_flg", {28'h0, bus.flags}, 32'h0);
        set_alu(ALU_SLT, 32'h0, 32'hFFFF_FFFF);
        check("slt_res", bus.alu_result, 32'h0);
        check("slt_flg", {28'h0, bus.flags}, 32'h4);
        set_alu(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and_res", bus.alu_result, 32'h00F0_1200);
        set_alu(ALU_OR, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("or_res", bus.alu_result, 32'hFFF0_FF34);
        set_alu(ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("xor_res", bus.alu_result, 32'hFF00_ED34);
        set_alu(ALU_PASS_B, 32'h1234_5678, 32'hABCD_E000);
        check("passb_res", bus.alu_result, 32'hABCD_E000);
        set_alu(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("rsvd_res", bus.alu_result, 32'h0);
        check("rsvd_flg", {28'h0, bus.flags}, 32'h4);

        // JALR-style jump overrides branch bits
        bus.jump = 1'b1; bus.pc_target_src = 1'b0; bus.rs1_data = 32'h100;
        bus.imm = 32'hFFFF_FFFC; bus.branch = 6'b000010;
        set_alu(ALU_SUB, 32'd5, 32'd5);
        check("jmp_target", bus.pc_target, 32'hFC);
        check("jmp_next", bus.pc_next, 32'hFC);
        check("jmp_src", {31'h0, bus.pc_next_src}, 32'h1);

        // PC increment wraps
        bus.jump = 1'b0; bus.branch = '0; bus.pc = 32'hFFFF_FFFF; #1;
        check("pcinc_wrap", bus.pc_plus_inc, 32'h0);
        check("pcinc_next", bus.pc_next, 32'h0);

        // Registered trace: held in reset across an edge, then captures
        bus.pc = 32'h40;
        set_alu(ALU_ADD, 32'd3, 32'd4);
        bus.jump = 1'b1;
        @(posedge clk); #1;
        check("held_rst_q", bus.result_q, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("pre_edge_q", bus.result_q, 32'h0);
        @(posedge clk); #1;
        check("cap_result_q", bus.result_q, 32'h7);
        check("cap_flags_q", {28'h0, bus.flags_q}, 32'h0);
        check("cap_taken_q", {31'h0, bus.taken_q}, 32'h1);
        bus.jump = 1'b0;
        set_alu(ALU_SUB, 32'd5, 32'd5);
        @(posedge clk); #1;
        check("cap2_result_q", bus.result_q, 32'h0);
        check("cap2_flags_q", {28'h0, bus.flags_q}, 32'h6);
        check("cap2_taken_q", {31'h0, bus.taken_q}, 32'h0);
        set_alu(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        bus.jump = 1'b1;
        @(posedge clk); #1;
        check("cap3_result_q", bus.result_q, 32'h8000_0000);
        check("cap3_flags_q", {28'h0, bus.flags_q}, 32'h9);

        // Mid-cycle asynchronous reset
        #2 rst = 1'b0;
        #1;
        check("async_result_q", bus.result_q, 32'h0);
        check("async_flags_q", {28'h0, bus.flags_q}, 32'h0);
        check("async_taken_q", {31'h0, bus.taken_q}, 32'h0);
        check("async_comb_res", bus.alu_result, 32'h8000_0000);
        check("async_comb_src", {31'h0, bus.pc_next_src}, 32'h1);
        @(posedge clk); #1;
        check("async_hold_q", bus.result_q, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_q", bus.result_q, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
